// File: rtl/conv_mac_ctrl.sv
// -----------------------------------------------------------------------------
// conv_mac_ctrl
//   Tile sequencer for the 27-lane MAC datapath of layer0. Issues one buffer
//   read per accepted slot (linear address pix*num_grp + grp). It accumulates
//   the returned MAC group sums per output pixel and adds the tile bias. The
//   result is requantized with an arithmetic right shift, then ReLU and
//   saturation give one unsigned 8-bit activation per pixel.
//
//   Optional build macro: CONV_MAC_CTRL_ROUND_EN
//     defined   -> round-half-up before the requantization shift
//     undefined -> truncating (floor) arithmetic shift
//
//   Ports
//     clk, rstn        clock, asynchronous active-low reset
//     start            one-cycle tile start, honoured only when idle
//     cfg_num_grp      groups of 27 products per output pixel
//     cfg_num_pix      output pixels in the tile
//     cfg_bias         signed bias added to every pixel
//     cfg_shift        requantization right shift
//     buf_rdy          buffers accept a read this cycle
//     rd_en, rd_addr   registered buffer read strobe and linear address
//     mac_vld_i        MAC input valid (rd_en delayed by the 1-cycle read)
//     mac_acc          MAC group sum (signed, MAC_W bits)
//     mac_vld_o        MAC group sum valid
//     o_vld, o_data    output activation strobe and value
//     busy             tile in progress
//     done             one-cycle pulse at tile completion
// -----------------------------------------------------------------------------
module conv_mac_ctrl #(
    parameter int ADDR_W = 24,
    parameter int ACC_W  = 32,
    parameter int MAC_W  = 21
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        cfg_num_grp,
    input  logic [15:0]       cfg_num_pix,
    input  logic [15:0]       cfg_bias,
    input  logic [4:0]        cfg_shift,
    input  logic              buf_rdy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              mac_vld_i,
    input  logic [MAC_W-1:0]  mac_acc,
    input  logic              mac_vld_o,
    output logic              o_vld,
    output logic [7:0]        o_data,
    output logic              busy,
    output logic              done
);

    // Read/return counters must hold num_grp * num_pix (8 + 16 bits).
    localparam int CNT_W = 24;

    localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic signed [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ReLU followed by saturation to the unsigned 8-bit range.
    function automatic logic [7:0] relu_sat_u8(input logic signed [ACC_W-1:0] v);
        logic [7:0] r;
        if (v[ACC_W-1]) begin
            r = 8'd0;
        end else if (|v[ACC_W-2:8]) begin
            r = 8'hFF;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    state_t                   state_q, state_d;
    logic [7:0]               grp_cfg_q, grp_cfg_d;
    logic signed [15:0]       bias_q, bias_d;
    logic [4:0]               shift_q, shift_d;
    logic [CNT_W-1:0]         total_q, total_d;
    logic [CNT_W-1:0]         issue_q, issue_d;
    logic [CNT_W-1:0]         ret_q, ret_d;
    logic [7:0]               grp_cnt_q, grp_cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0]        addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic                     rd_en_q, rd_en_d;
    logic                     mac_vld_i_q, mac_vld_i_d;
    logic                     o_vld_q, o_vld_d;
    logic [7:0]               o_data_q, o_data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     active_s;
    logic                     issue_s;
    logic                     last_issue_s;
    logic                     ret_s;
    logic                     last_grp_s;
    logic [CNT_W-1:0]         tile_len_s;
    logic signed [ACC_W-1:0]  mac_ext_s;
    logic signed [ACC_W-1:0]  bias_ext_s;
    logic signed [ACC_W-1:0]  acc_sum_s;
    logic signed [ACC_W-1:0]  round_s;
    logic signed [ACC_W-1:0]  pre_s;
    logic signed [ACC_W-1:0]  shr_s;

    assign active_s     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign issue_s      = (state_q == ST_RUN) && buf_rdy && (issue_q != total_q);
    assign last_issue_s = issue_s && ((issue_q + 24'd1) == total_q);
    // Returns are only meaningful inside a tile; stray strobes while idle are dropped.
    assign ret_s        = active_s && mac_vld_o;
    assign last_grp_s   = (grp_cnt_q == (grp_cfg_q - 8'd1));
    assign tile_len_s   = CNT_W'(cfg_num_grp) * CNT_W'(cfg_num_pix);

    assign mac_ext_s  = {{(ACC_W-MAC_W){mac_acc[MAC_W-1]}}, mac_acc};
    assign bias_ext_s = {{(ACC_W-16){bias_q[15]}}, bias_q};
    // First group of a pixel restarts the sum instead of adding to the stale one.
    assign acc_sum_s  = (grp_cnt_q == 8'd0) ? mac_ext_s : (acc_q + mac_ext_s);

`ifdef CONV_MAC_CTRL_ROUND_EN
    assign round_s = (shift_q != 5'd0) ? (ACC_ONE << (shift_q - 5'd1)) : ACC_ZERO;
`else
    assign round_s = ACC_ZERO;
`endif

    assign pre_s = acc_sum_s + bias_ext_s + round_s;
    assign shr_s = pre_s >>> shift_q;

    // Next-state logic of the tile sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((cfg_num_grp == 8'd0) || (cfg_num_pix == 16'd0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_issue_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // o_vld_q high with all returns counted means the final pixel is out.
                if ((ret_q == total_q) && o_vld_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next-state: config latch, read issue, accumulation and finalize.
    always_comb begin
        grp_cfg_d   = grp_cfg_q;
        bias_d      = bias_q;
        shift_d     = shift_q;
        total_d     = total_q;
        issue_d     = issue_q;
        ret_d       = ret_q;
        grp_cnt_d   = grp_cnt_q;
        acc_d       = acc_q;
        addr_cnt_d  = addr_cnt_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = 1'b0;
        mac_vld_i_d = rd_en_q;
        o_vld_d     = 1'b0;
        o_data_d    = o_data_q;

        if ((state_q == ST_IDLE) && start) begin
            grp_cfg_d  = cfg_num_grp;
            bias_d     = cfg_bias;
            shift_d    = cfg_shift;
            total_d    = tile_len_s;
            issue_d    = {CNT_W{1'b0}};
            ret_d      = {CNT_W{1'b0}};
            grp_cnt_d  = 8'd0;
            addr_cnt_d = {ADDR_W{1'b0}};
        end else begin
            grp_cfg_d  = grp_cfg_q;
        end

        if (issue_s) begin
            rd_en_d    = 1'b1;
            rd_addr_d  = addr_cnt_q;
            addr_cnt_d = addr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            issue_d    = issue_q + 24'd1;
        end else begin
            rd_en_d    = 1'b0;
        end

        if (ret_s) begin
            ret_d = ret_q + 24'd1;
            acc_d = acc_sum_s;
            if (last_grp_s) begin
                grp_cnt_d = 8'd0;
                o_vld_d   = 1'b1;
                o_data_d  = relu_sat_u8(shr_s);
            end else begin
                grp_cnt_d = grp_cnt_q + 8'd1;
            end
        end else begin
            acc_d = acc_q;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            grp_cfg_q   <= 8'd0;
            bias_q      <= 16'sd0;
            shift_q     <= 5'd0;
            total_q     <= {CNT_W{1'b0}};
            issue_q     <= {CNT_W{1'b0}};
            ret_q       <= {CNT_W{1'b0}};
            grp_cnt_q   <= 8'd0;
            acc_q       <= ACC_ZERO;
            addr_cnt_q  <= {ADDR_W{1'b0}};
            rd_addr_q   <= {ADDR_W{1'b0}};
            rd_en_q     <= 1'b0;
            mac_vld_i_q <= 1'b0;
            o_vld_q     <= 1'b0;
            o_data_q    <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_cfg_q   <= grp_cfg_d;
            bias_q      <= bias_d;
            shift_q     <= shift_d;
            total_q     <= total_d;
            issue_q     <= issue_d;
            ret_q       <= ret_d;
            grp_cnt_q   <= grp_cnt_d;
            acc_q       <= acc_d;
            addr_cnt_q  <= addr_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            mac_vld_i_q <= mac_vld_i_d;
            o_vld_q     <= o_vld_d;
            o_data_q    <= o_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign mac_vld_i = mac_vld_i_q;
    assign o_vld     = o_vld_q;
    assign o_data    = o_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
